// File: rtl/sw_input_sampler.sv
`default_nettype none
// ============================================================================
// Module   : sw_input_sampler
// Purpose  : Avalon-MM slave for the board switch/button bank. Raw pins are
//            synchronised, debounced on a slow sample tick, and debounced
//            rising edges are latched into a write-1-to-clear capture
//            register that drives a maskable level interrupt.
// Revision : 1.0 - initial release
//
// Ports
//   clk        in   1      system clock
//   reset_n    in   1      synchronous active-low reset
//   address    in   2      register select
//                          (0 deb, 1 irqmask, 2 edgecapture, 3 sync raw)
//   chipselect in   1      slave select
//   read       in   1      read strobe, qualified by chipselect
//   write      in   1      write strobe, qualified by chipselect
//   writedata  in   32     write data
//   readdata   out  32     registered read data, zero-extended
//   in_port    in   WIDTH  raw asynchronous switch inputs
//   irq        out  1      level interrupt, active high
//
// Build option
//   SW_SAMPLER_BOTHEDGE_EN : when defined, edgecapture also sets on
//                            debounced falling edges (press and release).
// ============================================================================
module sw_input_sampler #(
   parameter int WIDTH      = 8,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int c_PW = $clog2(TICK_DIV);
   localparam int c_CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);
   localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(STABLE_CNT - 1);

   logic [WIDTH-1:0]           sync1_q;
   logic [WIDTH-1:0]           sync2_q;
   logic [c_PW-1:0]            presc_q, presc_d;
   logic [WIDTH-1:0][c_CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]           deb_q, deb_d;
   logic [WIDTH-1:0]           edgecap_q, edgecap_d;
   logic [WIDTH-1:0]           irqmask_q, irqmask_d;
   logic [31:0]                readdata_q, readdata_d;

   logic                       w_tick;
   logic                       w_wr_en;
   logic [WIDTH-1:0]           w_edge_set;
   logic [WIDTH-1:0]           w_edge_clr;
   logic [31:0]                w_rd_sel;

   // Sample-tick prescaler
   assign w_tick  = (presc_q == c_TICK_LAST);
   assign presc_d = w_tick ? '0 : presc_q + c_PW'(1);

   // Per-bit debounce: a differing level must be seen on STABLE_CNT
   // consecutive ticks; any tick that agrees with deb restarts the count.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_tick) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == c_CNT_LAST) begin
               deb_d[i] = ~deb_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + c_CW'(1);
            end
         end
      end
   end

`ifdef SW_SAMPLER_BOTHEDGE_EN
   assign w_edge_set = deb_d ^ deb_q;
`else
   assign w_edge_set = deb_d & ~deb_q;
`endif

   assign w_wr_en    = chipselect & write;
   assign w_edge_clr = (w_wr_en && (address == 2'd2)) ? writedata[WIDTH-1:0] : '0;
   // Set is OR-ed after the clear so a coincident new edge is never lost.
   assign edgecap_d  = (edgecap_q & ~w_edge_clr) | w_edge_set;
   assign irqmask_d  = (w_wr_en && (address == 2'd1)) ? writedata[WIDTH-1:0] : irqmask_q;

   // Read mux works on current register values, so a read coinciding with
   // a write returns the pre-write contents.
   always_comb begin
      w_rd_sel = '0;
      case (address)
         2'd0:    w_rd_sel[WIDTH-1:0] = deb_q;
         2'd1:    w_rd_sel[WIDTH-1:0] = irqmask_q;
         2'd2:    w_rd_sel[WIDTH-1:0] = edgecap_q;
         default: w_rd_sel[WIDTH-1:0] = sync2_q;
      endcase
   end

   assign readdata_d = (chipselect && read) ? w_rd_sel : readdata_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         presc_q    <= '0;
         cnt_q      <= '0;
         deb_q      <= '0;
         edgecap_q  <= '0;
         irqmask_q  <= '0;
         readdata_q <= '0;
      end else begin
         sync1_q    <= in_port;
         sync2_q    <= sync1_q;
         presc_q    <= presc_d;
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         edgecap_q  <= edgecap_d;
         irqmask_q  <= irqmask_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire
